// File: rtl/axi_vdma_pkg.sv
// Shared VDMA types: write-client FSM states, AXI encodings and a constant log2 helper.
package axi_vdma_pkg;

  typedef enum logic [2:0] {IDLE, REQ, ARB, ADDR, DATA, RESP, DONE} wr_client_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_wr_burst_client_if.sv
// Command, write-data stream, lock-arbiter and AXI4 write-channel signals of the write client.
interface axi_wr_burst_client_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic                    cmd_valid, cmd_ready;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic                    din_valid, din_ready;
  logic [DATA_WIDTH-1:0]   din_data;
  logic                    wr_req, pend_wr, wr_done, err;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;

  modport master (
    input  cmd_valid, cmd_addr, din_valid, din_data, pend_wr, awready, wready, bid, bresp, bvalid,
    output cmd_ready, din_ready, wr_req, wr_done, err, awid, awaddr, awlen, awsize, awburst,
           awvalid, wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output cmd_valid, cmd_addr, din_valid, din_data, pend_wr, awready, wready, bid, bresp, bvalid,
    input  cmd_ready, din_ready, wr_req, wr_done, err, awid, awaddr, awlen, awsize, awburst,
           awvalid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/axi_wr_burst_client.sv
// Write-channel lock client: requests the bus, waits out pend_wr, then runs one AXI4 INCR burst.
// States: IDLE accept cmd | REQ 1-cycle request | ARB wait pend_wr low | ADDR AW | DATA W beats | RESP B | DONE release pulse
module axi_wr_burst_client
  import axi_vdma_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   DATA_WIDTH = 64,
  parameter int                   ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0]  AXI_ID     = '0,
  parameter int                   BURST_LEN  = 16
) (
  input  logic                   clock,
  input  logic                   rst_n,
  axi_wr_burst_client_if.master  bus
);

  localparam int                 CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam int                 SIZE_LOG2 = clog2(DATA_WIDTH / 8);

  wr_client_e            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic                  r_cmd_ready, r_wr_req, r_awvalid, r_in_data, r_bready, r_wr_done;
  logic                  w_cmd_ready_nxt, w_wr_req_nxt, w_awvalid_nxt, w_in_data_nxt;
  logic                  w_bready_nxt, w_wr_done_nxt;
  logic                  w_cmd_fire, w_aw_fire, w_w_fire, w_b_fire, w_last_beat;
  logic                  w_unused;

  assign w_cmd_fire  = r_cmd_ready & bus.cmd_valid;
  assign w_aw_fire   = r_awvalid & bus.awready;
  assign w_w_fire    = r_in_data & bus.din_valid & bus.wready;
  assign w_b_fire    = r_bready & bus.bvalid;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  assign w_unused    = ^bus.bid;

  // Moore flags are registered from the next state so they all read 0 while in reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_wr_req    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_in_data   <= 1'b0;
      r_bready    <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_wr_req    <= w_wr_req_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_in_data   <= w_in_data_nxt;
      r_bready    <= w_bready_nxt;
      r_wr_done   <= w_wr_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_fire) w_state_nxt = REQ;
      REQ:     w_state_nxt = ARB;
      ARB:     if (!bus.pend_wr) w_state_nxt = ADDR;
      ADDR:    if (w_aw_fire) w_state_nxt = DATA;
      DATA:    if (w_w_fire && w_last_beat) w_state_nxt = RESP;
      RESP:    if (w_b_fire) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_cmd_ready_nxt = (w_state_nxt == IDLE);
    w_wr_req_nxt    = (w_state_nxt == REQ) || (w_state_nxt == ARB);
    w_awvalid_nxt   = (w_state_nxt == ADDR);
    w_in_data_nxt   = (w_state_nxt == DATA);
    w_bready_nxt    = (w_state_nxt == RESP);
    w_wr_done_nxt   = (w_state_nxt == DONE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_awaddr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_cmd_fire) r_awaddr <= bus.cmd_addr;
      if (w_w_fire) r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.wr_req    = r_wr_req;
  assign bus.wr_done   = r_wr_done;
  assign bus.err       = w_b_fire & (bus.bresp != AXI_RESP_OKAY);
  assign bus.awid      = AXI_ID;
  assign bus.awaddr    = r_awaddr;
  assign bus.awlen     = 8'(BURST_LEN - 1);
  assign bus.awsize    = 3'(SIZE_LOG2);
  assign bus.awburst   = AXI_BURST_INCR;
  assign bus.awvalid   = r_awvalid;
  assign bus.wdata     = bus.din_data;
  assign bus.wstrb     = '1;
  assign bus.wlast     = r_in_data & w_last_beat;
  assign bus.wvalid    = r_in_data & bus.din_valid;
  assign bus.din_ready = r_in_data & bus.wready;
  assign bus.bready    = r_bready;

endmodule

// File: tb/tb_axi_wr_burst_client.sv
// Randomized bench for axi_wr_burst_client: burst-level reference model for BURST_LEN=4 and 1.
module tb_axi_wr_burst_client;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  axi_wr_burst_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus4 ();
  axi_wr_burst_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus1 ();

  axi_wr_burst_client #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(4'd0), .BURST_LEN(4)
  ) dut4 (.clock(clock), .rst_n(rst_n), .bus(bus4.master));

  axi_wr_burst_client #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(4'd0), .BURST_LEN(1)
  ) dut1 (.clock(clock), .rst_n(rst_n), .bus(bus1.master));

  virtual axi_wr_burst_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) vif;

  int n_checks = 0;
  int n_errors = 0;
  int bl;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    vif.cmd_valid = 1'b0;
    vif.cmd_addr  = '0;
    vif.din_valid = 1'b0;
    vif.din_data  = '0;
    vif.pend_wr   = 1'b0;
    vif.awready   = 1'b0;
    vif.wready    = 1'b0;
    vif.bid       = '0;
    vif.bresp     = 2'b00;
    vif.bvalid    = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, ".cmd_ready"}, vif.cmd_ready, 0);
    check_eq({tag, ".din_ready"}, vif.din_ready, 0);
    check_eq({tag, ".wr_req"},    vif.wr_req, 0);
    check_eq({tag, ".wr_done"},   vif.wr_done, 0);
    check_eq({tag, ".err"},       vif.err, 0);
    check_eq({tag, ".awvalid"},   vif.awvalid, 0);
    check_eq({tag, ".wvalid"},    vif.wvalid, 0);
    check_eq({tag, ".wlast"},     vif.wlast, 0);
    check_eq({tag, ".bready"},    vif.bready, 0);
    check_eq({tag, ".awaddr"},    vif.awaddr, 0);
  endtask

  // One complete transaction. pend_wr is high for the first pend_cyc cycles after acceptance,
  // so awvalid is expected at cycle max(3, pend_cyc+2). abort_at>0 resets after that many beats.
  task automatic run_burst(input logic [31:0] addr, input int pend_cyc, input int aw_dly,
                           input int w_pct, input int d_pct, input int b_dly,
                           input logic [1:0] bresp, input int abort_at);
    logic [63:0] beats[$];
    int   n, n_low, aw_cnt, idx, guard;
    logic dv, wr, hs;
    for (int i = 0; i < bl; i++) beats.push_back({$urandom, $urandom});

    @(posedge clock); #1;
    vif.cmd_valid = 1'b1;
    vif.cmd_addr  = addr;
    vif.pend_wr   = (pend_cyc > 0);
    dv = 1'b1;
    vif.din_valid = dv;
    vif.din_data  = beats[0];
    vif.wready    = 1'b1;
    guard = 0;
    @(negedge clock);
    while (!vif.cmd_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check_eq("cmd_accept", vif.cmd_ready, 1);
    @(posedge clock); #1;
    vif.cmd_valid = 1'b0;

    n_low = (pend_cyc + 1 > 2) ? pend_cyc + 1 : 2;
    n = 1;
    forever begin
      @(negedge clock);
      check_eq("wr_req", vif.wr_req, n <= n_low);
      check_eq("awvalid_timing", vif.awvalid, n > n_low);
      check_eq("wvalid_before_aw", vif.wvalid, 0);
      check_eq("cmd_ready_busy", vif.cmd_ready, 0);
      if (n > n_low) break;
      @(posedge clock); #1;
      n++;
      vif.pend_wr = (n <= pend_cyc);
      if (n == n_low + 1) vif.awready = (aw_dly == 0);
    end

    check_eq("awlen", vif.awlen, bl - 1);
    check_eq("awsize", vif.awsize, 3);
    check_eq("awburst", vif.awburst, 2'b01);
    check_eq("awid", vif.awid, 0);
    check_eq("wstrb", vif.wstrb, 8'hFF);
    aw_cnt = 0;
    forever begin
      check_eq("awvalid_hold", vif.awvalid, 1);
      check_eq("awaddr", vif.awaddr, addr);
      check_eq("wvalid_before_aw", vif.wvalid, 0);
      aw_cnt++;
      if (vif.awready) break;
      @(posedge clock); #1;
      vif.awready = (aw_cnt >= aw_dly);
      @(negedge clock);
    end
    check_eq("aw_cycles", aw_cnt, aw_dly + 1);

    @(posedge clock); #1;
    vif.awready = 1'b0;
    wr = ($urandom_range(99) < w_pct);
    vif.wready = wr;
    idx = 0;
    guard = 0;
    while (idx < bl && guard < 400) begin
      @(negedge clock);
      check_eq("wvalid", vif.wvalid, dv);
      check_eq("din_ready", vif.din_ready, wr);
      check_eq("awvalid_in_data", vif.awvalid, 0);
      if (dv) begin
        check_eq("wdata", vif.wdata, beats[idx]);
        check_eq("wlast", vif.wlast, idx == bl - 1);
      end
      hs = dv & wr;
      if (hs) idx++;
      if (abort_at > 0 && idx == abort_at) begin
        @(posedge clock); #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        drive_idle();
        @(posedge clock); #2;
        rst_n = 1'b1;
        return;
      end
      @(posedge clock); #1;
      if (hs || !dv) dv = (idx < bl) && ($urandom_range(99) < d_pct);
      vif.din_valid = dv;
      vif.din_data  = dv ? beats[idx] : {$urandom, $urandom};
      wr = ($urandom_range(99) < w_pct);
      vif.wready = wr;
      guard++;
    end
    check_eq("beat_count", idx, bl);
    vif.din_valid = 1'b0;

    for (int k = 0; k < b_dly; k++) begin
      @(negedge clock);
      check_eq("bready_wait", vif.bready, 1);
      check_eq("err_wait", vif.err, 0);
      check_eq("wr_done_early", vif.wr_done, 0);
      check_eq("wvalid_resp", vif.wvalid, 0);
      @(posedge clock); #1;
    end
    vif.bvalid = 1'b1;
    vif.bresp  = bresp;
    vif.bid    = IW'($urandom);
    @(negedge clock);
    check_eq("bready_hs", vif.bready, 1);
    check_eq("err", vif.err, bresp != 2'b00);
    check_eq("wr_done_at_b", vif.wr_done, 0);
    @(posedge clock); #1;
    vif.bvalid = 1'b0;
    vif.bresp  = 2'b00;
    @(negedge clock);
    check_eq("wr_done", vif.wr_done, 1);
    check_eq("err_after_b", vif.err, 0);
    check_eq("bready_done", vif.bready, 0);
    check_eq("cmd_ready_done", vif.cmd_ready, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("wr_done_pulse", vif.wr_done, 0);
    check_eq("cmd_ready_idle", vif.cmd_ready, 1);
  endtask

  initial begin
    logic [1:0] resp;
    int r;
    vif = bus1; bl = 1; drive_idle();
    vif = bus4; bl = 4; drive_idle();
    #1 rst_n = 1'b0;
    #1;
    vif = bus1; check_outputs_zero("reset1");
    vif = bus4; check_outputs_zero("reset4");
    repeat (2) @(posedge clock);
    #2 rst_n = 1'b1;

    run_burst(32'h0000_1000, 0, 0, 100, 100, 0, 2'b00, 0);
    run_burst(32'h0000_2000, 20, 0, 100, 100, 1, 2'b00, 0);
    run_burst(32'h0000_3000, 0, 1, 50, 50, 2, 2'b00, 0);
    run_burst(32'h0000_4000, 0, 0, 100, 100, 0, 2'b10, 0);
    run_burst(32'h0000_5000, 0, 0, 100, 100, 0, 2'b00, 2);
    run_burst(32'h0000_5040, 0, 0, 100, 100, 0, 2'b00, 0);
    repeat (10) begin
      r = $urandom_range(0, 3);
      resp = (r == 2) ? 2'b10 : (r == 3) ? 2'b11 : 2'b00;
      run_burst($urandom & 32'hFFFF_FFF8, $urandom_range(0, 6), $urandom_range(0, 3),
                $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 3), resp, 0);
    end

    vif = bus1; bl = 1;
    run_burst(32'h0000_6000, 0, 5, 100, 100, 0, 2'b00, 0);
    run_burst(32'h0000_6100, 3, 2, 40, 40, 1, 2'b10, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
